multi_alarm_controller: RTL and testbench

//  N-channel countdown alarm controller: the parametrised successor of the single-channel alarm FSM.

---
 rtl/alarm_pkg.sv | 27 ++
 rtl/alarm_channel.sv | 77 +++++++
 rtl/multi_alarm_controller.sv | 103 ++++++++++
 tb/tb_multi_alarm_controller.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and helpers for the multi-channel countdown alarm.
// State encodings match the chState output field.
package alarm_pkg;

  typedef enum logic [1:0] {
    SET   = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    BEEP  = 2'd3
  } alarm_state_t;

  localparam logic [1:0] ST_SET   = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_BEEP  = 2'd3;

  // Clamp a raw load value to the largest count a cnt_w counter holds.
  function automatic logic [63:0] sat_load(
    input logic [63:0] raw,
    input int unsigned cnt_w
  );
    logic [63:0] max_v;
    max_v = (64'd1 << cnt_w) - 64'd1;
    return (raw > max_v) ? max_v : raw;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One countdown channel: SET/RUN/PAUSE/BEEP FSM with its counter.
// Snooze input and logic exist only when SNOOZE_EN is defined.
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int SNOOZE_TICKS = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             start,
  input  logic             clr,
`ifdef SNOOZE_EN
  input  logic             snz,
`endif
  input  logic             tick,
  input  logic [CNT_W-1:0] load,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       state
);

`ifdef SNOOZE_EN
  localparam logic [63:0] SNZ_RAW = sat_load(64'(SNOOZE_TICKS), CNT_W);
  localparam logic [CNT_W-1:0] SNZ_VAL = CNT_W'(SNZ_RAW);
`endif

  alarm_state_t     state_d, state_q;
  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      SET: begin
        if (sel) count_d = load;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (start) state_d = PAUSE;
        else if (count_q == '0) state_d = BEEP;
        else if (tick) count_d = count_q - CNT_W'(1);
      end
      PAUSE: begin
        if (start) state_d = RUN;
      end
      BEEP: begin
        count_d = '0;
`ifdef SNOOZE_EN
        if (snz) begin
          state_d = RUN;
          count_d = SNZ_VAL;
        end
`endif
      end
    endcase
    // Clear outranks every other command and always reloads.
    if (clr) begin
      state_d = SET;
      count_d = load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SET;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign state = state_q;

endmodule

// File: rtl/multi_alarm_controller.sv
// N-channel countdown alarm: input sync/edge detect, channel select, load.
// Define SNOOZE_EN to add the snooze button and BEEP->RUN snooze path.
module multi_alarm_controller
  import alarm_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SW_W         = 9,
  parameter int SCALE        = 100,
  parameter int CNT_W        = 16,
  parameter int SNOOZE_TICKS = 500,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    mainClk,
  input  logic                    reset,
  input  logic                    timeClk,
  input  logic [SW_W-1:0]         switches,
  input  logic [CH_W-1:0]         chSel,
  input  logic                    pauseResume,
  input  logic                    clear,
`ifdef SNOOZE_EN
  input  logic                    snooze,
`endif
  output logic [NUM_CH*CNT_W-1:0] timeRemaining,
  output logic [NUM_CH*2-1:0]     chState,
  output logic [NUM_CH-1:0]       beepMask,
  output logic                    shouldBeep
);

  localparam int PROD_W = SW_W + $clog2(SCALE + 1);
`ifdef SNOOZE_EN
  localparam int NIN = 4;
`else
  localparam int NIN = 3;
`endif

  logic [NIN-1:0] async_in;
  logic [NIN-1:0] s1_d, s1_q;
  logic [NIN-1:0] s2_d, s2_q;
  logic [NIN-1:0] dly_d, dly_q;
  logic [NIN-1:0] pulse;

`ifdef SNOOZE_EN
  assign async_in = {snooze, clear, pauseResume, timeClk};
`else
  assign async_in = {clear, pauseResume, timeClk};
`endif

  always_comb begin
    s1_d  = async_in;
    s2_d  = s1_q;
    dly_d = s2_q;
  end

  always_ff @(posedge mainClk or posedge reset) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      dly_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      dly_q <= dly_d;
    end
  end

  // One-cycle pulse per rising edge of each synchronized input.
  assign pulse = s2_q & ~dly_q;

  logic [PROD_W-1:0] prod;
  logic [CNT_W-1:0]  load;

  assign prod = PROD_W'(switches) * PROD_W'(SCALE);
  assign load = CNT_W'(sat_load(64'(prod), CNT_W));

  logic [NUM_CH-1:0] sel;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign sel[k] = (NUM_CH == 1) || (chSel == CH_W'(k));

    alarm_channel #(
      .CNT_W       (CNT_W),
      .SNOOZE_TICKS(SNOOZE_TICKS)
    ) u_ch (
      .clk  (mainClk),
      .rst  (reset),
      .sel  (sel[k]),
      .start(pulse[1] & sel[k]),
      .clr  (pulse[2] & sel[k]),
`ifdef SNOOZE_EN
      .snz  (pulse[3] & sel[k]),
`endif
      .tick (pulse[0]),
      .load (load),
      .count(timeRemaining[k*CNT_W +: CNT_W]),
      .state(chState[2*k +: 2])
    );

    assign beepMask[k] = (chState[2*k +: 2] == ST_BEEP);
  end

  assign shouldBeep = |beepMask;

endmodule

// File: tb/tb_multi_alarm_controller.sv
// Scoreboarded random/directed bench for multi_alarm_controller.
// Array-based reference model; monitor pops expected snapshots.
module tb_multi_alarm_controller;

  localparam int NCH   = 4;
  localparam int SCALE = 100;
  localparam int MAXC  = 65535;
  localparam int SNZ   = 500;

  localparam int S_SET   = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_BEEP  = 3;

  logic        mainClk = 1'b0;
  logic        reset;
  logic        timeClk;
  logic [8:0]  switches;
  logic [1:0]  chSel;
  logic        pauseResume;
  logic        clear;
`ifdef SNOOZE_EN
  logic        snooze;
`endif
  logic [63:0] timeRemaining;
  logic [7:0]  chState;
  logic [3:0]  beepMask;
  logic        shouldBeep;

  multi_alarm_controller dut (
    .mainClk      (mainClk),
    .reset        (reset),
    .timeClk      (timeClk),
    .switches     (switches),
    .chSel        (chSel),
    .pauseResume  (pauseResume),
    .clear        (clear),
`ifdef SNOOZE_EN
    .snooze       (snooze),
`endif
    .timeRemaining(timeRemaining),
    .chState      (chState),
    .beepMask     (beepMask),
    .shouldBeep   (shouldBeep)
  );

  always #5 mainClk = ~mainClk;

  typedef struct packed {
    logic [63:0] tr;
    logic [7:0]  cs;
    logic [3:0]  bm;
    logic        sb;
  } snap_t;

  snap_t exp_q[$];
  int n_chk  = 0;
  int n_fail = 0;

  int m_st  [NCH];
  int m_cnt [NCH];
  int cur_sel = 0;
  int cur_sw  = 0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int load_of(int sw);
    int v;
    v = sw * SCALE;
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic snap_t mk_snap();
    snap_t s;
    s = '0;
    for (int k = 0; k < NCH; k++) begin
      s.tr[k*16 +: 16] = 16'(m_cnt[k]);
      s.cs[k*2 +: 2]   = 2'(m_st[k]);
      s.bm[k]          = (m_st[k] == S_BEEP);
    end
    s.sb = |s.bm;
    return s;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_st[k]  = S_SET;
      m_cnt[k] = 0;
    end
  endfunction

  // Conditions that resolve on their own between commands.
  function automatic void model_settle();
    if (m_st[cur_sel] == S_SET) m_cnt[cur_sel] = load_of(cur_sw);
    for (int k = 0; k < NCH; k++)
      if (m_st[k] == S_RUN && m_cnt[k] == 0) m_st[k] = S_BEEP;
  endfunction

  function automatic void model_event(bit t, bit p, bit c, bit s);
    for (int k = 0; k < NCH; k++) begin
      bit hit;
      hit = (k == cur_sel);
      if (hit && c) begin
        m_st[k]  = S_SET;
        m_cnt[k] = load_of(cur_sw);
      end else if (hit && p && m_st[k] != S_BEEP) begin
        m_st[k] = (m_st[k] == S_RUN) ? S_PAUSE : S_RUN;
      end else if (hit && s && m_st[k] == S_BEEP) begin
        m_st[k]  = S_RUN;
        m_cnt[k] = SNZ;
      end else if (t && m_st[k] == S_RUN && m_cnt[k] > 0) begin
        m_cnt[k] = m_cnt[k] - 1;
      end
    end
  endfunction

  task automatic apply_event(bit t, bit p, bit c, bit s);
    @(negedge mainClk);
    timeClk     = t;
    pauseResume = p;
    clear       = c;
`ifdef SNOOZE_EN
    snooze      = s;
`endif
    repeat (4) @(negedge mainClk);
    timeClk     = 1'b0;
    pauseResume = 1'b0;
    clear       = 1'b0;
`ifdef SNOOZE_EN
    snooze      = 1'b0;
`endif
    repeat (4) @(negedge mainClk);
    model_event(t, p, c, s);
    model_settle();
    exp_q.push_back(mk_snap());
  endtask

  task automatic set_inputs(int sel, int sw);
    @(negedge mainClk);
    chSel    = 2'(sel);
    switches = 9'(sw);
    repeat (3) @(negedge mainClk);
    cur_sel = sel;
    cur_sw  = sw;
    model_settle();
    exp_q.push_back(mk_snap());
  endtask

  task automatic run_ticks(int n);
    for (int i = 0; i < n; i++) apply_event(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  always @(posedge mainClk) begin
    snap_t e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("timeRemaining", timeRemaining, e.tr);
      check("chState", 64'(chState), 64'(e.cs));
      check("beepMask", 64'(beepMask), 64'(e.bm));
      check("shouldBeep", 64'(shouldBeep), 64'(e.sb));
    end
  end

  initial begin
    reset       = 1'b1;
    timeClk     = 1'b0;
    pauseResume = 1'b0;
    clear       = 1'b0;
`ifdef SNOOZE_EN
    snooze      = 1'b0;
`endif
    switches    = '0;
    chSel       = '0;
    model_reset();
    exp_q.push_back(mk_snap());
    repeat (3) @(negedge mainClk);
    reset = 1'b0;
    set_inputs(0, 1);

    // Reset mid-RUN with ch0 at 37
    apply_event(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(63);
    check("ch0_at_37", 64'(timeRemaining[15:0]), 64'd37);
    @(negedge mainClk);
    #2 reset = 1'b1;
    #1;
    check("rst_timeRemaining", timeRemaining, 64'd0);
    check("rst_chState", 64'(chState), 64'd0);
    check("rst_shouldBeep", 64'(shouldBeep), 64'd0);
    model_reset();
    exp_q.push_back(mk_snap());
    repeat (3) @(negedge mainClk);
    reset = 1'b0;
    set_inputs(0, 0);

    // ch1 counts 300 down into BEEP
    set_inputs(1, 3);
    apply_event(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(300);
    check("ch1_beepMask", 64'(beepMask), 64'h2);
    apply_event(1'b0, 1'b0, 1'b1, 1'b0);

    // ch0 pause holds count, resume continues
    set_inputs(0, 1);
    apply_event(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(95);
    apply_event(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(10);
    check("ch0_paused_at_5", 64'(timeRemaining[15:0]), 64'd5);
    apply_event(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(3);

    // Load saturation boundary
    set_inputs(2, 9'h1FF);
    check("ch2_load_max", 64'(timeRemaining[47:32]), 64'd51100);

    // ch2 same-cycle collisions
    set_inputs(2, 1);
    apply_event(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(10);
    apply_event(1'b1, 1'b0, 1'b1, 1'b0);
    apply_event(1'b0, 1'b1, 1'b0, 1'b0);
    run_ticks(4);
    apply_event(1'b1, 1'b1, 1'b0, 1'b0);
    run_ticks(2);

`ifdef SNOOZE_EN
    set_inputs(3, 0);
    apply_event(1'b0, 1'b1, 1'b0, 1'b0);
    apply_event(1'b0, 1'b0, 1'b0, 1'b1);
    run_ticks(500);
    apply_event(1'b0, 1'b0, 1'b1, 1'b1);
`endif

    // Randomized commands
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 20) begin
        int sw;
        sw = ($urandom_range(0, 19) == 0) ? 511 : int'($urandom_range(0, 2));
        set_inputs(int'($urandom_range(0, 3)), sw);
      end else begin
        bit t, p, c, s;
        t = ($urandom_range(0, 9) < 7);
        p = ($urandom_range(0, 9) < 2);
        c = ($urandom_range(0, 9) < 1);
        s = ($urandom_range(0, 9) < 2);
`ifndef SNOOZE_EN
        s = 1'b0;
`endif
        if (!(t || p || c || s)) t = 1'b1;
        apply_event(t, p, c, s);
      end
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge mainClk);
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d snapshots left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
